halton_vertex_pair: RTL and testbench
=====================================

HALTON_VERTEX_PAIR -- requirements
Module: halton_vertex_pair

Interface
REQ-001 SHALL have parameters: MAP_WIDTH, default 1000, map side length; FIFO_DEPTH, default 4 (power of 2, ≥2), per-axis input FIFO depth; VW = $clog2(MAP_WIDTH+1), derived coordinate width.
REQ-002 SHALL have ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
start_i  in  1  begin a run, sampled in IDLE/DONE only
numNode_i  in  16  vertices to emit, latched on accepted start_i
x_value_i  in  VW  base-2 Halton coordinate
x_index_i  in  16  sequence index of x_value_i
x_valid_i  in  1  x word present
x_ready_o  out  1  x word accepted when x_valid_i & x_ready_o
y_value_i  in  VW  base-3 Halton coordinate
y_index_i  in  16  sequence index of y_value_i
y_valid_i  in  1  y word present
y_ready_o  out  1  y word accepted when y_valid_i & y_ready_o
vertex_x_o  out  VW  paired x coordinate
vertex_y_o  out  VW  paired y coordinate
vertex_index_o  out  16  index of the pair (taken from x head)
vertex_valid_o  out  1  vertex present
vertex_ready_i  in  1  vertex consumed when vertex_valid_o & vertex_ready_i
busy_o  out  1  state == RUN
done_o  out  1  state == DONE
error_o  out  1  sticky index-mismatch flag (see Configuration)

Function
REQ-003 SHALL implement states IDLE, RUN, DONE.
REQ-004 IDLE/DONE -> RUN on start_i=1 when numNode_i≠0; latch numNode_i, clear emitted counter, FIFOs, output register, error_o.
REQ-005 IDLE/DONE with start_i=1 and numNode_i=0 SHALL go to DONE next cycle, emitting nothing.
REQ-006 x_ready_o/y_ready_o SHALL equal (state==RUN) & (own FIFO not full); depends only on registered state, no combinational path from any input.
REQ-007 Input words offered while not ready SHALL be ignored, not stored.
REQ-008 Each axis SHALL have an independent FIFO_DEPTH-entry FIFO of {value,index}; push on accepted input, pop on pair; simultaneous push and pop on a non-full FIFO SHALL keep occupancy constant.
REQ-009 A pair SHALL fire when both FIFOs non-empty, state==RUN, and output register empty or consumed this cycle; fire pops both heads in the same cycle and loads the output register.
REQ-010 Latency: x and y accepted on edge E into empty FIFOs with empty output register -> vertex_valid_o high after edge E+1.
REQ-011 Output register SHALL hold vertex_* stable while vertex_valid_o=1 and vertex_ready_i=0.
REQ-012 Back-to-back: with vertex_ready_i held 1 and both FIFOs non-empty, one vertex per cycle.
REQ-013 Emitted counter (16 bit) SHALL increment on each output handshake; when it reaches latched numNode_i, state -> DONE on that edge; no further pairs fire; residual FIFO entries discarded on next start.
REQ-014 Total fires SHALL never exceed latched numNode_i; pairing stops once fires == numNode_i even if output not yet consumed; RUN->DONE on final handshake.
REQ-015 start_i during RUN SHALL be ignored.
REQ-016 Coordinates SHALL pass through unmodified; no width conversion.

Reset
REQ-017 reset=0 SHALL asynchronously force: state IDLE, FIFOs empty, emitted counter 0, vertex_valid_o 0, vertex_x_o/vertex_y_o/vertex_index_o 0, busy_o 0, done_o 0, error_o 0, x_ready_o/y_ready_o 0.
REQ-018 Reset asserted mid-run SHALL discard all buffered words; after deassertion, nothing is emitted until a new start_i.

Configuration
REQ-019 Macro HALTON_PAIR_IDXCHECK_EN defined: on each fire, if x head index ≠ y head index, error_o SHALL set (sticky until reset or accepted start_i); the pair is still emitted with the x index.
REQ-020 Macro undefined: no comparator; error_o SHALL be tied 0.

Verification
REQ-021 numNode_i=3, start; x/y indices 0,1,2 pushed same cycles, vertex_ready_i=1 -> three vertices indices 0,1,2, first valid after edge E+1, then done_o=1, busy_o=0.
REQ-022 Push 4 x words, no y, FIFO_DEPTH=4 -> x_ready_o=0 after 4th; 5th x word ignored; then 4 y words -> 4 vertices in order.
REQ-023 vertex_ready_i=0 for 5 cycles with vertex valid (x=500,y=333,idx=1) -> outputs stable; ready=1 -> single handshake, no duplicate.
REQ-024 numNode_i=0, start -> done_o=1 next cycle, vertex_valid_o never 1.
REQ-025 With macro: x index 5 paired with y index 6 -> error_o=1 and stays 1; without macro error_o=0.
REQ-026 reset=0 asynchronously mid-run with 2 words buffered -> all outputs zero immediately; after release no vertex until start_i.

Source files
------------

// File: rtl/halton_vertex_pair.sv
// ---------------------------------------------------------------------------
// halton_vertex_pair
//
// Pairs a base-2 Halton x stream with a base-3 Halton y stream into vertices.
// Each axis feeds its own small FIFO. A vertex fires when both FIFOs hold a
// word and the output register is free. A run emits exactly numNode_i
// vertices and then parks in DONE.
//
// Parameters:
//   MAP_WIDTH  - map side length
//   FIFO_DEPTH - per-axis FIFO depth (power of 2, >= 2)
//   VW         - coordinate width, $clog2(MAP_WIDTH+1)
//
// Ports:
//   clk, reset            - clock (rising edge), async active-low reset
//   start_i, numNode_i    - start a run of numNode_i vertices (IDLE/DONE only)
//   x_value_i/x_index_i   - x word, valid/ready handshake (x_valid_i/x_ready_o)
//   y_value_i/y_index_i   - y word, valid/ready handshake (y_valid_i/y_ready_o)
//   vertex_x_o/y_o/index_o- paired vertex, valid/ready handshake
//   busy_o, done_o        - state == RUN / state == DONE
//   error_o               - sticky x/y index mismatch flag
//
// Optional feature macro: HALTON_PAIR_IDXCHECK_EN
//   defined   - compare head indices on each fire; set error_o on mismatch
//   undefined - no comparator, error_o tied low
// ---------------------------------------------------------------------------
module halton_vertex_pair #(
   parameter int unsigned MAP_WIDTH  = 1000,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned VW         = $clog2(MAP_WIDTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_i,
   input  logic [15:0]   numNode_i,
   input  logic [VW-1:0] x_value_i,
   input  logic [15:0]   x_index_i,
   input  logic          x_valid_i,
   output logic          x_ready_o,
   input  logic [VW-1:0] y_value_i,
   input  logic [15:0]   y_index_i,
   input  logic          y_valid_i,
   output logic          y_ready_o,
   output logic [VW-1:0] vertex_x_o,
   output logic [VW-1:0] vertex_y_o,
   output logic [15:0]   vertex_index_o,
   output logic          vertex_valid_o,
   input  logic          vertex_ready_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          error_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [15:0]   num_q;
   logic [15:0]   emitted_q;
   logic [15:0]   fired_q;

   logic [VW-1:0] x_val_mem [FIFO_DEPTH];
   logic [15:0]   x_idx_mem [FIFO_DEPTH];
   logic [VW-1:0] y_val_mem [FIFO_DEPTH];
   logic [15:0]   y_idx_mem [FIFO_DEPTH];
   logic [AW-1:0] x_wr_q, x_rd_q, y_wr_q, y_rd_q;
   logic [CW-1:0] x_cnt_q, y_cnt_q;

   logic          vld_q;
   logic [VW-1:0] vx_q, vy_q;
   logic [15:0]   vidx_q;

   logic          run;
   logic          x_push, y_push;
   logic          x_empty, y_empty;
   logic          hs, fire, start_acc, last_hs;
   logic [VW-1:0] x_val_head, y_val_head;
   logic [15:0]   x_idx_head, y_idx_head;

   assign run        = (state_q == StRun);
   // Ready comes only from registered state and occupancy.
   assign x_ready_o  = run & (x_cnt_q != FullCnt);
   assign y_ready_o  = run & (y_cnt_q != FullCnt);
   assign x_push     = x_valid_i & x_ready_o;
   assign y_push     = y_valid_i & y_ready_o;
   assign x_empty    = (x_cnt_q == '0);
   assign y_empty    = (y_cnt_q == '0);
   assign x_val_head = x_val_mem[x_rd_q];
   assign x_idx_head = x_idx_mem[x_rd_q];
   assign y_val_head = y_val_mem[y_rd_q];
   assign y_idx_head = y_idx_mem[y_rd_q];

   assign hs        = vld_q & vertex_ready_i;
   // Fires are capped at numNode even while the last vertex waits in the register.
   assign fire      = run & ~x_empty & ~y_empty & (~vld_q | vertex_ready_i) &
                      (fired_q != num_q);
   assign start_acc = start_i & ~run;
   assign last_hs   = hs & ((emitted_q + 16'd1) == num_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d = (numNode_i != 16'd0) ? StRun : StDone;
            end
         end
         StRun: begin
            if (last_hs) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FIFO storage needs no reset; occupancy counters define what is valid.
   always_ff @(posedge clk) begin
      if (x_push) begin
         x_val_mem[x_wr_q] <= x_value_i;
         x_idx_mem[x_wr_q] <= x_index_i;
      end
      if (y_push) begin
         y_val_mem[y_wr_q] <= y_value_i;
         y_idx_mem[y_wr_q] <= y_index_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num_q     <= '0;
         emitted_q <= '0;
         fired_q   <= '0;
         x_wr_q    <= '0;
         x_rd_q    <= '0;
         x_cnt_q   <= '0;
         y_wr_q    <= '0;
         y_rd_q    <= '0;
         y_cnt_q   <= '0;
         vld_q     <= 1'b0;
         vx_q      <= '0;
         vy_q      <= '0;
         vidx_q    <= '0;
      end else if (start_acc) begin
         // Leftover words from the previous run are discarded here.
         num_q     <= numNode_i;
         emitted_q <= '0;
         fired_q   <= '0;
         x_wr_q    <= '0;
         x_rd_q    <= '0;
         x_cnt_q   <= '0;
         y_wr_q    <= '0;
         y_rd_q    <= '0;
         y_cnt_q   <= '0;
         vld_q     <= 1'b0;
         vx_q      <= '0;
         vy_q      <= '0;
         vidx_q    <= '0;
      end else begin
         if (x_push) x_wr_q <= x_wr_q + 1'b1;
         if (y_push) y_wr_q <= y_wr_q + 1'b1;
         if (fire) begin
            x_rd_q <= x_rd_q + 1'b1;
            y_rd_q <= y_rd_q + 1'b1;
         end

         if (x_push && !fire) begin
            x_cnt_q <= x_cnt_q + 1'b1;
         end else if (!x_push && fire) begin
            x_cnt_q <= x_cnt_q - 1'b1;
         end
         if (y_push && !fire) begin
            y_cnt_q <= y_cnt_q + 1'b1;
         end else if (!y_push && fire) begin
            y_cnt_q <= y_cnt_q - 1'b1;
         end

         if (fire) fired_q <= fired_q + 16'd1;
         if (hs) emitted_q <= emitted_q + 16'd1;

         if (fire) begin
            vld_q  <= 1'b1;
            vx_q   <= x_val_head;
            vy_q   <= y_val_head;
            vidx_q <= x_idx_head;
         end else if (hs) begin
            vld_q  <= 1'b0;
         end
      end
   end

   assign vertex_valid_o = vld_q;
   assign vertex_x_o     = vx_q;
   assign vertex_y_o     = vy_q;
   assign vertex_index_o = vidx_q;
   assign busy_o         = run;
   assign done_o         = (state_q == StDone);

`ifdef HALTON_PAIR_IDXCHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (start_acc) begin
         err_q <= 1'b0;
      end else if (fire && (x_idx_head != y_idx_head)) begin
         err_q <= 1'b1;
      end
   end

   assign error_o = err_q;
`else
   // y index is carried through the FIFO but only consumed by the checker.
   logic unused_y_idx;
   assign unused_y_idx = ^y_idx_head;
   assign error_o      = 1'b0;
`endif

endmodule

// File: tb/tb_halton_vertex_pair.sv
// Scoreboard bench for halton_vertex_pair: the monitor models the run as
// "k-th accepted x pairs with k-th accepted y, first numNode pairs only".
module tb_halton_vertex_pair;

   localparam int MapWidth = 1000;
   localparam int VW       = $clog2(MapWidth + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start_i = 1'b0;
   logic [15:0]   numNode_i = '0;
   logic [VW-1:0] x_value_i = '0;
   logic [15:0]   x_index_i = '0;
   logic          x_valid_i = 1'b0;
   logic          x_ready_o;
   logic [VW-1:0] y_value_i = '0;
   logic [15:0]   y_index_i = '0;
   logic          y_valid_i = 1'b0;
   logic          y_ready_o;
   logic [VW-1:0] vertex_x_o;
   logic [VW-1:0] vertex_y_o;
   logic [15:0]   vertex_index_o;
   logic          vertex_valid_o;
   logic          vertex_ready_i = 1'b0;
   logic          busy_o;
   logic          done_o;
   logic          error_o;

   halton_vertex_pair #(
      .MAP_WIDTH (MapWidth),
      .FIFO_DEPTH(4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start_i       (start_i),
      .numNode_i     (numNode_i),
      .x_value_i     (x_value_i),
      .x_index_i     (x_index_i),
      .x_valid_i     (x_valid_i),
      .x_ready_o     (x_ready_o),
      .y_value_i     (y_value_i),
      .y_index_i     (y_index_i),
      .y_valid_i     (y_valid_i),
      .y_ready_o     (y_ready_o),
      .vertex_x_o    (vertex_x_o),
      .vertex_y_o    (vertex_y_o),
      .vertex_index_o(vertex_index_o),
      .vertex_valid_o(vertex_valid_o),
      .vertex_ready_i(vertex_ready_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .error_o       (error_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [VW-1:0] v;
      logic [15:0]   i;
   } word_t;

   typedef struct packed {
      logic [VW-1:0] x;
      logic [VW-1:0] y;
      logic [15:0]   i;
   } vert_t;

   typedef enum {MIdle, MRun, MDone} mstate_t;

   word_t   xq[$];
   word_t   yq[$];
   vert_t   expq[$];
   mstate_t mst = MIdle;
   int      m_num = 0;
   int      m_fired = 0;
   int      m_got = 0;
   bit      m_err = 1'b0;
   bit      hold = 1'b0;
   vert_t   held;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor / reference model, sampled on the falling edge.
   always @(negedge clk) begin
      vert_t e;
      vert_t cur;
      if (!reset) begin
         xq.delete();
         yq.delete();
         expq.delete();
         mst  = MIdle;
         hold = 1'b0;
      end else begin
         cur = '{x: vertex_x_o, y: vertex_y_o, i: vertex_index_o};
         check("busy", busy_o, (mst == MRun));
         check("done", done_o, (mst == MDone));
         check("x_ready_outside_run", x_ready_o & (mst != MRun), 0);
         check("y_ready_outside_run", y_ready_o & (mst != MRun), 0);
         check("valid_without_expected", vertex_valid_o & (expq.size() == 0), 0);
         if (hold) begin
            check("hold_valid", vertex_valid_o, 1);
            check("hold_data", cur, held);
         end
         if (vertex_valid_o && vertex_ready_i && expq.size() > 0) begin
            e = expq.pop_front();
            check("vertex_x", vertex_x_o, e.x);
            check("vertex_y", vertex_y_o, e.y);
            check("vertex_index", vertex_index_o, e.i);
            m_got++;
            if (m_got == m_num) mst = MDone;
         end
         hold = vertex_valid_o & ~vertex_ready_i;
         held = cur;

         if (mst != MRun && start_i) begin
            xq.delete();
            yq.delete();
            expq.delete();
            m_num   = int'(numNode_i);
            m_fired = 0;
            m_got   = 0;
            m_err   = 1'b0;
            hold    = 1'b0;
            mst     = (numNode_i != 16'd0) ? MRun : MDone;
         end else if (mst == MRun) begin
            if (x_valid_i && x_ready_o) xq.push_back('{v: x_value_i, i: x_index_i});
            if (y_valid_i && y_ready_o) yq.push_back('{v: y_value_i, i: y_index_i});
            while (xq.size() > 0 && yq.size() > 0 && m_fired < m_num) begin
               word_t wx;
               word_t wy;
               wx = xq.pop_front();
               wy = yq.pop_front();
               expq.push_back('{x: wx.v, y: wy.v, i: wx.i});
               if (wx.i != wy.i) m_err = 1'b1;
               m_fired++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start_i   = 1'b1;
      numNode_i = 16'(n);
      tick();
      start_i   = 1'b0;
   endtask

   task automatic drive_x(input bit v, input int val, input int idx);
      x_valid_i = v;
      x_value_i = VW'(val);
      x_index_i = 16'(idx);
   endtask

   task automatic drive_y(input bit v, input int val, input int idx);
      y_valid_i = v;
      y_value_i = VW'(val);
      y_index_i = 16'(idx);
   endtask

   task automatic check_err(input string name);
`ifdef HALTON_PAIR_IDXCHECK_EN
      check(name, error_o, m_err);
`else
      check(name, error_o, 0);
`endif
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = done_o;
      end
      check({name, "_reached_done"}, seen, 1);
      check_err({name, "_error"});
      tick();
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_valid"}, vertex_valid_o, 0);
      check({name, "_x"}, vertex_x_o, 0);
      check({name, "_y"}, vertex_y_o, 0);
      check({name, "_idx"}, vertex_index_o, 0);
      check({name, "_busy"}, busy_o, 0);
      check({name, "_done"}, done_o, 0);
      check({name, "_error"}, error_o, 0);
      check({name, "_x_ready"}, x_ready_o, 0);
      check({name, "_y_ready"}, y_ready_o, 0);
   endtask

   initial begin
      // Reset state
      #3 reset = 1'b0;
      #9;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Three vertices, x/y pushed in the same cycles, first-vertex latency
      vertex_ready_i = 1'b1;
      do_start(3);
      drive_x(1, 11, 0);
      drive_y(1, 22, 0);
      tick();                               // edge E accepts index 0
      drive_x(1, 512, 1);
      drive_y(1, 333, 1);
      @(negedge clk);
      check("latency_after_E", vertex_valid_o, 0);
      tick();                               // edge E+1
      drive_x(1, 999, 2);
      drive_y(1, 1000, 2);
      @(negedge clk);
      check("latency_after_E1", vertex_valid_o, 1);
      tick();
      drive_x(0, 0, 0);
      drive_y(0, 0, 0);
      wait_done("three", 50);
      @(negedge clk);
      check("three_done_o", done_o, 1);
      check("three_busy_o", busy_o, 0);
      tick();

      // FIFO full: four x words, a fifth ignored, then y words drain in order
      do_start(5);
      for (int k = 0; k < 4; k++) begin
         drive_x(1, 100 + k, k);
         tick();
      end
      drive_x(1, 777, 99);
      @(negedge clk);
      check("x_full_ready", x_ready_o, 0);
      check("y_empty_ready", y_ready_o, 1);
      tick();
      tick();
      drive_x(0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         drive_y(1, 200 + k, k);
         tick();
      end
      drive_x(1, 104, 4);
      drive_y(1, 204, 4);
      tick();
      drive_x(0, 0, 0);
      drive_y(0, 0, 0);
      wait_done("full", 50);

      // Back-pressure hold for several cycles, then a single handshake
      vertex_ready_i = 1'b0;
      do_start(1);
      drive_x(1, 500, 1);
      drive_y(1, 333, 1);
      tick();
      drive_x(0, 0, 0);
      drive_y(0, 0, 0);
      repeat (6) tick();
      check("stall_valid", vertex_valid_o, 1);
      check("stall_x", vertex_x_o, 500);
      check("stall_y", vertex_y_o, 333);
      check("stall_idx", vertex_index_o, 1);
      vertex_ready_i = 1'b1;
      wait_done("stall", 20);
      repeat (3) tick();

      // Zero-length run
      do_start(0);
      @(negedge clk);
      check("zero_done", done_o, 1);
      check("zero_valid", vertex_valid_o, 0);
      tick();
      tick();

      // Index mismatch
      do_start(1);
      drive_x(1, 40, 5);
      drive_y(1, 41, 6);
      tick();
      drive_x(0, 0, 0);
      drive_y(0, 0, 0);
      wait_done("mismatch", 20);
      repeat (3) tick();
      check_err("mismatch_sticky");

      // Randomized runs (matching indices, so error_o should clear on start)
      for (int r = 0; r < 6; r++) begin
         int  n;
         int  sx;
         int  sy;
         bit  seen;
         n    = int'($urandom_range(1, 12));
         sx   = 0;
         sy   = 0;
         seen = 1'b0;
         do_start(n);
         for (int c = 0; c < 400 && !seen; c++) begin
            vertex_ready_i = ($urandom_range(0, 3) != 0);
            drive_x((sx < n + 2) && ($urandom_range(0, 1) != 0),
                    int'($urandom_range(0, MapWidth)), sx);
            drive_y((sy < n + 2) && ($urandom_range(0, 1) != 0),
                    int'($urandom_range(0, MapWidth)), sy);
            @(negedge clk);
            if (x_valid_i && x_ready_o) sx++;
            if (y_valid_i && y_ready_o) sy++;
            seen = done_o;
            @(posedge clk);
            #1;
         end
         drive_x(0, 0, 0);
         drive_y(0, 0, 0);
         vertex_ready_i = 1'b1;
         check("random_reached_done", seen, 1);
         check_err("random_error");
         tick();
      end

      // Asynchronous reset mid-run with words buffered
      vertex_ready_i = 1'b0;
      do_start(4);
      drive_x(1, 300, 0);
      drive_y(1, 301, 0);
      tick();
      drive_y(0, 0, 0);
      drive_x(1, 310, 1);
      tick();
      drive_x(1, 320, 2);
      tick();
      drive_x(0, 0, 0);
      tick();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      vertex_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         drive_x(1, 50 + k, k);
         drive_y(1, 60 + k, k);
      end
      tick();
      drive_x(0, 0, 0);
      drive_y(0, 0, 0);
      check("post_reset_valid", vertex_valid_o, 0);
      check("post_reset_busy", busy_o, 0);
      do_start(1);
      drive_x(1, 7, 7);
      drive_y(1, 8, 7);
      tick();
      drive_x(0, 0, 0);
      drive_y(0, 0, 0);
      wait_done("post_reset_run", 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
